// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-facing controls/outputs plus the instruction-memory req/ack channel.
interface fetch_stage_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              stall;
  logic              redirect;
  logic [DWIDTH-1:0] redirect_addr;
  logic              imem_req;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [DWIDTH-1:0] imem_rdata;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] inst;
  logic              valid;

  modport master (
    input  stall, redirect, redirect_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, addr, inst, valid
  );

  modport slave (
    output stall, redirect, redirect_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, addr, inst, valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, holds under stall, flushes on redirect.
// Define FETCH_PERF_CNT_EN to add the 32-bit fetch_cnt delivered-instruction counter port.
module fetch_stage #(
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0,
  parameter logic [DWIDTH-1:0] PC_STEP  = DWIDTH'(4)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t            state;
  logic [DWIDTH-1:0] pc;
  logic [DWIDTH-1:0] disc_addr;
  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] inst_q;
  logic              valid_q;
  logic [DWIDTH-1:0] hb_addr;
  logic [DWIDTH-1:0] hb_inst;
  logic              hb_full;
  logic              load_mem;
  logic              load_hb;

  // A redirect that leaves a request unanswered keeps presenting the old
  // address until memory acks, so the handshake is never withdrawn.
  assign bus.imem_req  = rst && (state != HOLD);
  assign bus.imem_addr = (state == DISCARD) ? disc_addr : pc;
  assign bus.addr      = addr_q;
  assign bus.inst      = inst_q;
  assign bus.valid     = valid_q;

  always_comb begin
    load_mem = 1'b0;
    load_hb  = 1'b0;
    if (!bus.redirect && !bus.stall) begin
      load_mem = (state == FETCH) && bus.imem_ack;
      load_hb  = (state == HOLD) && hb_full;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      disc_addr <= RESET_PC;
      addr_q    <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
      hb_addr   <= '0;
      hb_inst   <= '0;
      hb_full   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.redirect) begin
            pc <= bus.redirect_addr;
            if (!bus.imem_ack) begin
              disc_addr <= pc;
              state     <= DISCARD;
            end
          end else if (bus.imem_ack) begin
            pc <= pc + PC_STEP;
            if (bus.stall) begin
              hb_addr <= pc;
              hb_inst <= bus.imem_rdata;
              hb_full <= 1'b1;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.redirect) begin
            pc    <= bus.redirect_addr;
            state <= FETCH;
          end else if (!bus.stall) begin
            hb_full <= 1'b0;
            state   <= FETCH;
          end
        end
        DISCARD: begin
          if (bus.redirect) begin
            pc <= bus.redirect_addr;
          end else if (bus.imem_ack) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase

      if (bus.redirect) begin
        valid_q <= 1'b0;
        hb_full <= 1'b0;
      end else if (load_mem) begin
        addr_q  <= pc;
        inst_q  <= bus.imem_rdata;
        valid_q <= 1'b1;
      end else if (load_hb) begin
        addr_q  <= hb_addr;
        inst_q  <= hb_inst;
        valid_q <= 1'b1;
      end else if (state == FETCH && !bus.imem_ack && !bus.stall) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
    end else if (load_mem || load_hb) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule
